// File: rtl/seg_scan_driver.sv
// Multiplexed seven-segment scan driver with a shadow/active code buffer.
// Latency: seg/an are registered one clock behind the slot counter and digit index.
// Backpressure: none; a load is always accepted and commits at the next frame boundary.
//
// Ports:
//   clk, rst_n          rising-edge clock, asynchronous active-low reset
//   codes               4 bits per digit, digit k at [4k+3:4k]
//   load                one-cycle strobe, captures codes into the shadow register
//   blank               forces every anode off while high; scanning keeps running
//   blink_mask          per-digit blink enable (only when SEG_BLINK_EN is defined)
//   seg                 active-low segments, seg[0]=a .. seg[6]=g
//   an                  active-low one-hot anode select
//   frame_done          pulse on the last cycle of the slot for the last digit
//   pending             shadow holds codes that have not been committed yet
//
// Optional feature: define SEG_BLINK_EN to add blink_mask and a frame counter
// whose MSB blanks the segments of masked digits (anode stays driven).
module seg_scan_driver #(
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV   = 1000,
  parameter int DEAD_CYC   = 2,
  parameter int BLINK_DIV  = 6
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] codes,
  input  logic                    load,
  input  logic                    blank,
`ifdef SEG_BLINK_EN
  input  logic [NUM_DIGITS-1:0]   blink_mask,
`endif
  output logic [6:0]              seg,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_done,
  output logic                    pending
);

  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int DW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [SW-1:0] SLOT_LAST  = SW'(SCAN_DIV - 1);
  localparam logic [SW-1:0] SLOT_PRE   = SW'(SCAN_DIV - 2);
  localparam logic [DW-1:0] DIGIT_LAST = DW'(NUM_DIGITS - 1);

  logic [SW-1:0]           r_slot;
  logic [DW-1:0]           r_digit;
  logic [4*NUM_DIGITS-1:0] r_shadow;
  logic [4*NUM_DIGITS-1:0] r_active;
  logic                    r_pending;
  logic                    r_frame_done;
  logic [6:0]              r_seg;
  logic [NUM_DIGITS-1:0]   r_an;

  logic                    w_dead;
  logic                    w_blink_off;
  logic [3:0]              w_code;
  logic [6:0]              w_seg_nxt;
  logic [NUM_DIGITS-1:0]   w_an_nxt;

  function automatic logic [6:0] glyph(input logic [3:0] c);
    case (c)
      4'h0: glyph = 7'h40;
      4'h1: glyph = 7'h79;
      4'h2: glyph = 7'h24;
      4'h3: glyph = 7'h30;
      4'h4: glyph = 7'h47;  // L
      4'h5: glyph = 7'h12;
      4'h6: glyph = 7'h3F;  // dash
      4'h7: glyph = 7'h78;
      4'h8: glyph = 7'h00;
      4'h9: glyph = 7'h09;  // H
      4'hA: glyph = 7'h08;
      4'hB: glyph = 7'h03;
      4'hC: glyph = 7'h46;
      4'hD: glyph = 7'h21;
      4'hE: glyph = 7'h06;
      default: glyph = 7'h7F;  // F shows as blank
    endcase
  endfunction

  // Slot counter and digit index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_slot  <= '0;
      r_digit <= '0;
    end else if (r_slot == SLOT_LAST) begin
      r_slot  <= '0;
      r_digit <= (r_digit == DIGIT_LAST) ? '0 : r_digit + 1'b1;
    end else begin
      r_slot  <= r_slot + 1'b1;
    end
  end

  // frame_done is registered from a one-cycle look-ahead so it lines up with
  // the counter state of the last slot cycle of the last digit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_frame_done <= 1'b0;
    else        r_frame_done <= (r_slot == SLOT_PRE) && (r_digit == DIGIT_LAST);
  end

  // Shadow/active buffering. A load on the frame boundary bypasses the shadow
  // wait and lands in the active register directly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shadow  <= '1;
      r_active  <= '1;
      r_pending <= 1'b0;
    end else begin
      if (load) r_shadow <= codes;
      if (r_frame_done) begin
        if (load)           r_active <= codes;
        else if (r_pending) r_active <= r_shadow;
        r_pending <= 1'b0;
      end else if (load) begin
        r_pending <= 1'b1;
      end
    end
  end

  generate
    if (DEAD_CYC == 0) begin : g_no_dead
      assign w_dead = 1'b0;
    end else begin : g_dead
      assign w_dead = (r_slot < SW'(DEAD_CYC));
    end
  endgenerate

  always_comb begin
    w_code = 4'hF;
    for (int k = 0; k < NUM_DIGITS; k++)
      if (r_digit == DW'(k)) w_code = r_active[4*k +: 4];
  end

`ifdef SEG_BLINK_EN
  logic [BLINK_DIV:0] r_frame_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)            r_frame_cnt <= '0;
    else if (r_frame_done) r_frame_cnt <= r_frame_cnt + 1'b1;
  end

  always_comb begin
    w_blink_off = 1'b0;
    for (int k = 0; k < NUM_DIGITS; k++)
      if (r_digit == DW'(k)) w_blink_off = r_frame_cnt[BLINK_DIV] & blink_mask[k];
  end
`else
  assign w_blink_off = 1'b0;
`endif

  always_comb begin
    w_an_nxt  = ~(NUM_DIGITS'(1) << r_digit);
    w_seg_nxt = glyph(w_code);
    if (blank || w_dead) begin
      w_an_nxt  = '1;
      w_seg_nxt = 7'h7F;
    end else if (w_blink_off) begin
      w_seg_nxt = 7'h7F;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_seg <= 7'h7F;
      r_an  <= '1;
    end else begin
      r_seg <= w_seg_nxt;
      r_an  <= w_an_nxt;
    end
  end

  assign seg        = r_seg;
  assign an         = r_an;
  assign frame_done = r_frame_done;
  assign pending    = r_pending;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Testbench for seg_scan_driver: directed scenarios plus randomized loads/blank,
// every cycle compared with a frame-position based reference model.
module tb_seg_scan_driver;
  localparam int ND = 4;
  localparam int SD = 8;
  localparam int DC = 2;
  localparam int BD = 1;
  localparam int P  = ND * SD;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] codes;
  logic        load;
  logic        blank;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic        frame_done;
  logic        pending;
`ifdef SEG_BLINK_EN
  logic [3:0]  blink_mask;
`endif

  always #5 clk = ~clk;

  seg_scan_driver #(
    .NUM_DIGITS(ND), .SCAN_DIV(SD), .DEAD_CYC(DC), .BLINK_DIV(BD)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .codes(codes),
    .load(load),
    .blank(blank),
`ifdef SEG_BLINK_EN
    .blink_mask(blink_mask),
`endif
    .seg(seg),
    .an(an),
    .frame_done(frame_done),
    .pending(pending)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [6:0] glyph_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h47, 7'h12, 7'h3F, 7'h78,
                                 7'h00, 7'h09, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h7F};

  // Reference model: position in frame is just the number of clock edges
  // since reset modulo the frame length.
  int         m_c;
  logic [3:0] m_active [4];
  logic [3:0] m_shadow [4];
  bit         m_pend;
  int         m_frames;
  logic [6:0] e_seg;
  logic [3:0] e_an;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_c = 0;
    m_pend = 1'b0;
    m_frames = 0;
    for (int k = 0; k < 4; k++) begin
      m_active[k] = 4'hF;
      m_shadow[k] = 4'hF;
    end
  endtask

  function automatic bit fd_now();
    return (m_c % P) == P - 1;
  endfunction

  // One clock with the inputs currently applied; outputs checked at negedge.
  task automatic cycle();
    int pos, digit, slot;
    bit fd_pre;
    @(posedge clk);
    pos    = m_c % P;
    digit  = pos / SD;
    slot   = pos % SD;
    fd_pre = (pos == P - 1);
    e_an  = 4'hF;
    e_seg = 7'h7F;
    if (!blank && slot >= DC) begin
      e_an  = ~(4'b0001 << digit);
      e_seg = glyph_tab[m_active[digit]];
`ifdef SEG_BLINK_EN
      if (((m_frames >> BD) & 1) == 1 && blink_mask[digit]) e_seg = 7'h7F;
`endif
    end
    if (fd_pre) begin
      if (load) for (int k = 0; k < 4; k++) m_active[k] = codes[4*k +: 4];
      else if (m_pend) for (int k = 0; k < 4; k++) m_active[k] = m_shadow[k];
      m_pend = 1'b0;
      m_frames++;
    end else if (load) begin
      m_pend = 1'b1;
    end
    if (load) for (int k = 0; k < 4; k++) m_shadow[k] = codes[4*k +: 4];
    m_c++;
    @(negedge clk);
    check("seg", {9'd0, seg}, {9'd0, e_seg});
    check("an", {12'd0, an}, {12'd0, e_an});
    check("frame_done", {15'd0, frame_done}, {15'd0, fd_now()});
    check("pending", {15'd0, pending}, {15'd0, m_pend});
  endtask

  task automatic do_load(input logic [15:0] v);
    codes = v;
    load  = 1'b1;
    cycle();
    load  = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    load  = 1'b0;
    blank = 1'b0;
    codes = 16'h0000;
`ifdef SEG_BLINK_EN
    blink_mask = 4'b0000;
`endif
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_seg", {9'd0, seg}, 16'h007F);
    check("rst_an", {12'd0, an}, 16'h000F);
    check("rst_fd", {15'd0, frame_done}, 16'h0000);
    check("rst_pend", {15'd0, pending}, 16'h0000);
    rst_n = 1'b1;

    // Idle: blank display, frame_done every P cycles.
    repeat (70) cycle();

    // Simple load and commit.
    do_load(16'h4321);
    check("pend_after_load", {15'd0, pending}, 16'h0001);
    repeat (70) cycle();

    // Two loads inside one frame: only the last commits.
    while (!fd_now()) cycle();
    cycle();
    do_load(16'h9999);
    repeat (5) cycle();
    do_load(16'h6A4E);
    repeat (70) cycle();

    // Load on the frame_done cycle commits directly.
    while (!fd_now()) cycle();
    do_load(16'hBCDE);
    check("pend_fd_load", {15'd0, pending}, 16'h0000);
    repeat (40) cycle();

    // Blank held for 10 cycles in the middle of a slot.
    while ((m_c % SD) != 4) cycle();
    blank = 1'b1;
    repeat (10) cycle();
    blank = 1'b0;
    repeat (40) cycle();

`ifdef SEG_BLINK_EN
    blink_mask = 4'b0010;
    repeat (5 * P) cycle();
`endif

    // Randomized loads, blanking and blink masks.
    for (int i = 0; i < 800; i++) begin
      codes = 16'($urandom);
      load  = ($urandom_range(0, 15) == 0);
      blank = ($urandom_range(0, 24) == 0);
`ifdef SEG_BLINK_EN
      if ($urandom_range(0, 99) == 0) blink_mask = 4'($urandom);
`endif
      cycle();
      load = 1'b0;
    end
    blank = 1'b0;

    // Reset mid-frame with a pending shadow: shadow is discarded.
    while (!fd_now()) cycle();
    cycle();
    do_load(16'h0123);
    repeat (7) cycle();
    rst_n = 1'b0;
    #1;
    check("arst_seg", {9'd0, seg}, 16'h007F);
    check("arst_an", {12'd0, an}, 16'h000F);
    check("arst_fd", {15'd0, frame_done}, 16'h0000);
    check("arst_pend", {15'd0, pending}, 16'h0000);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (80) cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
